imm_gen: RTL and testbench

- Decodes the RV32I instruction word into its sign-extended 32-bit immediate for the single-cycle CPU datapath.
- The combinational result feeds the ALU operand B mux, the branch/jump target adders and the LUI/AUIPC path in the same cycle.
- A registered copy, with format and valid tags, is also provided for pipelined or debug consumers.

---
 rtl/imm_gen.sv | 102 ++++++++++
 tb/tb_imm_gen.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/imm_gen.sv
// RV32I immediate decoder: combinational imm/fmt/imm_valid, plus a 1-cycle registered copy.
// No backpressure: en gates capture; rst (synchronous) clears the registered copy and wins over en.
module imm_gen #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     instr,
   input  logic            en,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt,
   output logic            imm_valid,
   output logic [XLEN-1:0] imm_q,
   output logic [2:0]      fmt_q,
   output logic            imm_valid_q
);

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5
   } fmt_t;

   typedef struct packed {
      logic [XLEN-1:0] imm;
      fmt_t            fmt;
      logic            vld;
   } imm_dat_t;

   localparam logic [6:0] OP_IMM   = 7'h13;
   localparam logic [6:0] OP_LOAD  = 7'h03;
   localparam logic [6:0] OP_JALR  = 7'h67;
   localparam logic [6:0] OP_MISC  = 7'h0F;
   localparam logic [6:0] OP_SYS   = 7'h73;
   localparam logic [6:0] OP_STORE = 7'h23;
   localparam logic [6:0] OP_BRCH  = 7'h63;
   localparam logic [6:0] OP_LUI   = 7'h37;
   localparam logic [6:0] OP_AUIPC = 7'h17;
   localparam logic [6:0] OP_JAL   = 7'h6F;

   logic [6:0]      opcode;
   logic            sign;
   fmt_t            fmt_dec;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   imm_dat_t        cur_dat, reg_dat;

   assign opcode = instr[6:0];
   assign sign   = instr[31];

   // Every format's immediate is built in parallel; the opcode only steers the final mux.
   assign imm_i = {{20{sign}}, instr[31:20]};
   assign imm_s = {{20{sign}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{sign}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'h000};
   assign imm_j = {{11{sign}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   always_comb begin
      fmt_dec = FMT_NONE;
      unique case (opcode)
         OP_IMM, OP_LOAD, OP_JALR, OP_MISC, OP_SYS: fmt_dec = FMT_I;
         OP_STORE:                                  fmt_dec = FMT_S;
         OP_BRCH:                                   fmt_dec = FMT_B;
         OP_LUI, OP_AUIPC:                          fmt_dec = FMT_U;
         OP_JAL:                                    fmt_dec = FMT_J;
         default:                                   fmt_dec = FMT_NONE;
      endcase
   end

   always_comb begin
      cur_dat     = '0;
      cur_dat.fmt = fmt_dec;
      cur_dat.vld = (fmt_dec != FMT_NONE);
      unique case (fmt_dec)
         FMT_I:   cur_dat.imm = imm_i;
         FMT_S:   cur_dat.imm = imm_s;
         FMT_B:   cur_dat.imm = imm_b;
         FMT_U:   cur_dat.imm = imm_u;
         FMT_J:   cur_dat.imm = imm_j;
         default: cur_dat.imm = '0;
      endcase
   end

   assign imm       = cur_dat.imm;
   assign fmt       = cur_dat.fmt;
   assign imm_valid = cur_dat.vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         reg_dat <= '0;
      end else if (en) begin
         reg_dat <= cur_dat;
      end
   end

   assign imm_q       = reg_dat.imm;
   assign fmt_q       = reg_dat.fmt;
   assign imm_valid_q = reg_dat.vld;

endmodule

// File: tb/tb_imm_gen.sv
// Directed table-driven bench for imm_gen: combinational decode table, then registered-path sequences.
`timescale 1ns/1ps
module tb_imm_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        en;
   logic [31:0] imm;
   logic [2:0]  fmt;
   logic        imm_valid;
   logic [31:0] imm_q;
   logic [2:0]  fmt_q;
   logic        imm_valid_q;

   int checks = 0;
   int errors = 0;

   imm_gen #(.XLEN(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .instr       (instr),
      .en          (en),
      .imm         (imm),
      .fmt         (fmt),
      .imm_valid   (imm_valid),
      .imm_q       (imm_q),
      .fmt_q       (fmt_q),
      .imm_valid_q (imm_valid_q)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [31:0] imm;
      logic [2:0]  fmt;
      logic        vld;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs.push_back('{"addi5",   32'h00500013, 32'h00000005, 3'd1, 1'b1});
      vecs.push_back('{"addi-1",  32'hFFF00013, 32'hFFFFFFFF, 3'd1, 1'b1});
      vecs.push_back('{"slli3",   32'h00301013, 32'h00000003, 3'd1, 1'b1});
      vecs.push_back('{"srli31",  32'h01F05013, 32'h0000001F, 3'd1, 1'b1});
      vecs.push_back('{"srai",    32'h40005013, 32'h00000400, 3'd1, 1'b1});
      vecs.push_back('{"lw16",    32'h01002003, 32'h00000010, 3'd1, 1'b1});
      vecs.push_back('{"lwneg",   32'h80002003, 32'hFFFFF800, 3'd1, 1'b1});
      vecs.push_back('{"jalr",    32'h7FF00067, 32'h000007FF, 3'd1, 1'b1});
      vecs.push_back('{"ecall",   32'h00000073, 32'h00000000, 3'd1, 1'b1});
      vecs.push_back('{"fence",   32'h0FF0000F, 32'h000000FF, 3'd1, 1'b1});
      vecs.push_back('{"sw20",    32'h00002A23, 32'h00000014, 3'd2, 1'b1});
      vecs.push_back('{"swneg",   32'hFE002823, 32'hFFFFFFF0, 3'd2, 1'b1});
      vecs.push_back('{"beq16",   32'h00000863, 32'h00000010, 3'd3, 1'b1});
      vecs.push_back('{"bneg",    32'hFE0008E3, 32'hFFFFFFF0, 3'd3, 1'b1});
      vecs.push_back('{"lui",     32'h12345037, 32'h12345000, 3'd4, 1'b1});
      vecs.push_back('{"auipc",   32'hABCDE017, 32'hABCDE000, 3'd4, 1'b1});
      vecs.push_back('{"jal2k",   32'h0010006F, 32'h00000800, 3'd5, 1'b1});
      vecs.push_back('{"jalneg",  32'h801FF06F, 32'hFFFFF800, 3'd5, 1'b1});
      vecs.push_back('{"rtype",   32'h00B50533, 32'h00000000, 3'd0, 1'b0});
      vecs.push_back('{"undef7f", 32'h0000007F, 32'h00000000, 3'd0, 1'b0});
      vecs.push_back('{"lowbits", 32'hFFFFFF12, 32'h00000000, 3'd0, 1'b0});

      rst   = 1'b1;
      en    = 1'b0;
      instr = 32'h0;

      // Combinational table, applied between clock edges.
      #2;
      foreach (vecs[i]) begin
         instr = vecs[i].instr;
         #1;
         check({vecs[i].name, ".imm"}, imm, vecs[i].imm);
         check({vecs[i].name, ".fmt"}, {29'd0, fmt}, {29'd0, vecs[i].fmt});
         check({vecs[i].name, ".vld"}, {31'd0, imm_valid}, {31'd0, vecs[i].vld});
      end

      // Reset state.
      rst = 1'b1; en = 1'b0; instr = 32'h801FF06F;
      tick();
      check("rst.imm_q", imm_q, 32'h0);
      check("rst.fmt_q", {29'd0, fmt_q}, 32'd0);
      check("rst.vld_q", {31'd0, imm_valid_q}, 32'd0);

      // One-cycle capture.
      rst = 1'b0; en = 1'b1;
      tick();
      check("cap.imm_q", imm_q, 32'hFFFFF800);
      check("cap.fmt_q", {29'd0, fmt_q}, 32'd5);
      check("cap.vld_q", {31'd0, imm_valid_q}, 32'd1);

      // Hold with en low while the combinational side follows instr.
      en = 1'b0; instr = 32'h00500013;
      tick();
      check("hold.imm_q", imm_q, 32'hFFFFF800);
      check("hold.fmt_q", {29'd0, fmt_q}, 32'd5);
      check("hold.imm", imm, 32'h00000005);
      tick();
      check("hold2.imm_q", imm_q, 32'hFFFFF800);

      // Capture of a NONE-format word clears valid.
      en = 1'b1; instr = 32'h00B50533;
      tick();
      check("none.imm_q", imm_q, 32'h0);
      check("none.vld_q", {31'd0, imm_valid_q}, 32'd0);

      // Capture an I-type, then reset and enable together: reset must win.
      instr = 32'h00500013;
      tick();
      check("capi.imm_q", imm_q, 32'h00000005);
      check("capi.fmt_q", {29'd0, fmt_q}, 32'd1);
      rst = 1'b1; en = 1'b1; instr = 32'hFFF00013;
      tick();
      check("prio.imm_q", imm_q, 32'h0);
      check("prio.fmt_q", {29'd0, fmt_q}, 32'd0);
      check("prio.vld_q", {31'd0, imm_valid_q}, 32'd0);
      check("prio.imm", imm, 32'hFFFFFFFF);
      check("prio.fmt", {29'd0, fmt}, 32'd1);

      // Release reset: capture resumes on the next edge.
      rst = 1'b0;
      tick();
      check("post.imm_q", imm_q, 32'hFFFFFFFF);
      check("post.vld_q", {31'd0, imm_valid_q}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
